// File: rtl/duty_cycle_controller_pkg.sv
// Shared definitions for the duty-cycle controller and the PWM generator it feeds.
// The repeat FSM type is only used when DUTY_AUTOREPEAT_EN is defined.
package duty_cycle_controller_pkg;

  localparam int DUTY_W           = 7;
  localparam int DUTY_MAX_DEFAULT = 100;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } repeat_state_t;

endpackage

// File: rtl/duty_cycle_controller_button_debouncer.sv
// One push-button channel: 2-flop synchroniser, counter debounce and a registered
// one-cycle press pulse on each accepted 0->1 change of the stable level.
module button_debouncer
  import duty_cycle_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             level_prev;
  logic [CNT_W-1:0] cnt;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      cnt        <= '0;
      press      <= 1'b0;
    end else begin
      sync_a     <= btn;
      sync_b     <= sync_a;
      if (sync_b != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_b;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
      level_prev <= level;
      press      <= level & ~level_prev;
    end
  end

endmodule

// File: rtl/duty_cycle_controller.sv
// Turns two debounced push-buttons into a saturating 7-bit duty-cycle command.
// Define DUTY_AUTOREPEAT_EN to keep stepping while a single button is held.
module duty_cycle_controller
  import duty_cycle_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP            = 10,
  parameter int DUTY_MAX        = DUTY_MAX_DEFAULT,
  parameter int DUTY_INIT       = 0,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_down,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              at_max,
  output logic              at_min
);

  localparam logic [7:0]        STEP8  = 8'(STEP);
  localparam logic [7:0]        MAX8   = 8'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] MAX_D  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INIT_D = DUTY_W'(DUTY_INIT);

  logic up_level, up_press, down_level, down_press;
  logic up_step, down_step;
  logic [7:0] sum;
  logic [DUTY_W-1:0] duty_next;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst(rst), .btn(btn_up), .level(up_level), .press(up_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .rst(rst), .btn(btn_down), .level(down_level), .press(down_press)
  );

`ifdef DUTY_AUTOREPEAT_EN
  localparam int RPT_MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W    = $clog2(RPT_MAXV + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  repeat_state_t    state, state_next;
  logic [RPT_W-1:0] rpt_cnt;
  logic             hold_up;
  logic             own_level, other_level, rpt_step;

  assign own_level   = hold_up ? up_level : down_level;
  assign other_level = hold_up ? down_level : up_level;

  // hold_up remembers which button started the hold so the FSM watches the right level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rpt_cnt <= '0;
      hold_up <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state || rpt_step || state == IDLE) begin
        rpt_cnt <= '0;
      end else begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
      if (state == IDLE && (up_press ^ down_press)) begin
        hold_up <= up_press;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (up_press ^ down_press) state_next = HOLD;
      HOLD:    if (!own_level || other_level) state_next = IDLE;
               else if (rpt_cnt == DELAY_LAST) state_next = REPEAT;
      REPEAT:  if (!own_level || other_level) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rpt_step = 1'b0;
    if (own_level && !other_level) begin
      case (state)
        HOLD:    rpt_step = (rpt_cnt == DELAY_LAST);
        REPEAT:  rpt_step = (rpt_cnt == PERIOD_LAST);
        default: rpt_step = 1'b0;
      endcase
    end
  end

  assign up_step   = up_press | (rpt_step & hold_up);
  assign down_step = down_press | (rpt_step & ~hold_up);
`else
  // Without auto-repeat the REPEAT_* parameters have no effect.
  logic repeat_params_unused;
  assign repeat_params_unused = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];

  assign up_step   = up_press;
  assign down_step = down_press;
`endif

  assign sum = {1'b0, duty_cycle} + STEP8;

  // Opposing steps in the same cycle cancel out.
  always_comb begin
    duty_next = duty_cycle;
    if (up_step && !down_step) begin
      duty_next = (sum > MAX8) ? MAX_D : DUTY_W'(sum);
    end else if (down_step && !up_step) begin
      duty_next = ({1'b0, duty_cycle} < STEP8) ? '0 : DUTY_W'({1'b0, duty_cycle} - STEP8);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_cycle <= INIT_D;
      at_max     <= (DUTY_INIT == DUTY_MAX);
      at_min     <= (DUTY_INIT == 0);
    end else begin
      duty_cycle <= duty_next;
      at_max     <= (duty_next == MAX_D);
      at_min     <= (duty_next == '0);
    end
  end

endmodule
